pwm_pulse_gen: RTL and testbench

//   Finite or continuous PWM pulse-train generator. A rising edge on io_en starts a train of
//   io_pusle_times periods; each period is io_pulseWidth active cycles then io_unaccessWidth idle cycles.

---
 rtl/pwm_pulse_pkg.sv | 13 +
 rtl/pwm_phase_counter.sv | 34 +++
 rtl/pwm_pulse_gen.sv | 136 +++++++++++++
 tb/tb_pwm_pulse_gen.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/pwm_pulse_pkg.sv
// Shared types and defaults for the PWM pulse-train generator.
package pwm_pulse_pkg;

  localparam int unsigned RAM_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/pwm_phase_counter.sv
// Loadable down-counter; tc is high while the count sits at zero.
module pwm_phase_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             tc
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/pwm_pulse_gen.sv
// Finite or continuous PWM pulse-train generator: N periods of W active
// cycles followed by U idle cycles, with completion strobe and busy flag.
module pwm_pulse_gen
  import pwm_pulse_pkg::*;
#(
  parameter int unsigned _RAM_WIDTH = RAM_WIDTH_DEFAULT
) (
  input  logic                  io_clk,
  input  logic                  io_rst,
  input  logic                  io_en,
  input  logic                  io_defaultLevel,
  input  logic [_RAM_WIDTH-1:0] io_pulseWidth,
  input  logic [_RAM_WIDTH-1:0] io_unaccessWidth,
  input  logic [_RAM_WIDTH-1:0] io_pusle_times,
  output logic                  io_pulseOut,
  output logic                  pulse_valid,
  output logic                  pulse_busy
);

  state_e                state_q, state_d;
  logic                  en_q;
  logic                  pulse_out_q, pulse_out_d;
  logic [_RAM_WIDTH-1:0] w_m1_q, w_m1_d;
  logic [_RAM_WIDTH-1:0] u_m1_q, u_m1_d;
  logic [_RAM_WIDTH-1:0] n_q, n_d;
  logic [_RAM_WIDTH-1:0] period_q, period_d;
  logic [_RAM_WIDTH-1:0] period_inc;
  logic [_RAM_WIDTH-1:0] ph_val;
  logic                  ph_load, ph_dec, ph_tc;
  logic                  start;

  // Phase lengths are stored minus one; a zero length behaves as one cycle.
  function automatic logic [_RAM_WIDTH-1:0] len_m1(input logic [_RAM_WIDTH-1:0] v);
    return (v == '0) ? '0 : v - _RAM_WIDTH'(1);
  endfunction

  pwm_phase_counter #(
    .WIDTH (_RAM_WIDTH)
  ) u_phase (
    .clk      (io_clk),
    .rst      (io_rst),
    .load     (ph_load),
    .load_val (ph_val),
    .dec      (ph_dec),
    .tc       (ph_tc)
  );

  assign start      = io_en & ~en_q & (state_q == IDLE);
  assign period_inc = (period_q == '1) ? period_q : period_q + _RAM_WIDTH'(1);

  always_comb begin
    state_d  = state_q;
    w_m1_d   = w_m1_q;
    u_m1_d   = u_m1_q;
    n_d      = n_q;
    period_d = period_q;
    ph_load  = 1'b0;
    ph_val   = w_m1_q;
    ph_dec   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          w_m1_d   = len_m1(io_pulseWidth);
          u_m1_d   = len_m1(io_unaccessWidth);
          n_d      = io_pusle_times;
          period_d = '0;
          ph_load  = 1'b1;
          ph_val   = len_m1(io_pulseWidth);
          state_d  = ACTIVE;
        end
      end
      ACTIVE: begin
        if (!io_en) begin
          state_d = IDLE;
        end else if (ph_tc) begin
          ph_load = 1'b1;
          ph_val  = u_m1_q;
          state_d = GAP;
        end else begin
          ph_dec = 1'b1;
        end
      end
      GAP: begin
        if (!io_en) begin
          state_d = IDLE;
        end else if (ph_tc) begin
          period_d = period_inc;
          if ((n_q != '0) && (period_inc == n_q)) begin
            state_d = DONE;
          end else begin
            ph_load = 1'b1;
            ph_val  = w_m1_q;
            state_d = ACTIVE;
          end
        end else begin
          ph_dec = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Output is registered off the next state so it lines up with busy.
    pulse_out_d = (state_d == ACTIVE) ? ~io_defaultLevel : io_defaultLevel;
  end

  always_ff @(posedge io_clk) begin
    if (io_rst) begin
      state_q     <= IDLE;
      en_q        <= 1'b0;
      pulse_out_q <= io_defaultLevel;
      w_m1_q      <= '0;
      u_m1_q      <= '0;
      n_q         <= '0;
      period_q    <= '0;
    end else begin
      state_q     <= state_d;
      en_q        <= io_en;
      pulse_out_q <= pulse_out_d;
      w_m1_q      <= w_m1_d;
      u_m1_q      <= u_m1_d;
      n_q         <= n_d;
      period_q    <= period_d;
    end
  end

  assign io_pulseOut = pulse_out_q;
  assign pulse_valid = (state_q == DONE);
  assign pulse_busy  = (state_q == ACTIVE) || (state_q == GAP);

endmodule

// File: tb/tb_pwm_pulse_gen.sv
// Directed and randomized bench for pwm_pulse_gen against a period-arithmetic
// model of the expected waveform.
module tb_pwm_pulse_gen;

  localparam int unsigned RW = 32;

  logic          io_clk = 1'b0;
  logic          io_rst;
  logic          io_en;
  logic          io_defaultLevel;
  logic [RW-1:0] io_pulseWidth;
  logic [RW-1:0] io_unaccessWidth;
  logic [RW-1:0] io_pusle_times;
  logic          io_pulseOut;
  logic          pulse_valid;
  logic          pulse_busy;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 io_clk = ~io_clk;

  pwm_pulse_gen #(
    ._RAM_WIDTH (RW)
  ) dut (
    .io_clk           (io_clk),
    .io_rst           (io_rst),
    .io_en            (io_en),
    .io_defaultLevel  (io_defaultLevel),
    .io_pulseWidth    (io_pulseWidth),
    .io_unaccessWidth (io_unaccessWidth),
    .io_pusle_times   (io_pusle_times),
    .io_pulseOut      (io_pulseOut),
    .pulse_valid      (pulse_valid),
    .pulse_busy       (pulse_busy)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge io_clk);
    #1;
  endtask

  task automatic check_idle(input string tag, input logic def);
    check({tag, ".out"}, io_pulseOut, def);
    check({tag, ".busy"}, pulse_busy, 1'b0);
    check({tag, ".valid"}, pulse_valid, 1'b0);
  endtask

  // Starts a train and checks `cycles` cycles after the start edge.
  // The model: cycle k lies in period k/(W+U); active while k mod (W+U) < W;
  // a finite train ends after N*(W+U) cycles with one valid cycle, then idle.
  task automatic run_train(input int unsigned n, input int unsigned w, input int unsigned u,
                           input logic def, input int unsigned cycles);
    int unsigned we, ue, p, total;
    logic exp_out, exp_busy, exp_valid;
    we = (w == 0) ? 1 : w;
    ue = (u == 0) ? 1 : u;
    p  = we + ue;
    total = n * p;
    io_defaultLevel  = def;
    io_pulseWidth    = RW'(w);
    io_unaccessWidth = RW'(u);
    io_pusle_times   = RW'(n);
    io_en            = 1'b1;
    for (int unsigned k = 0; k < cycles; k++) begin
      tick();
      if (k == 0) begin
        io_pulseWidth    = $urandom;
        io_unaccessWidth = $urandom;
        io_pusle_times   = $urandom;
      end
      if ((n != 0) && (k >= total)) begin
        exp_busy  = 1'b0;
        exp_valid = (k == total);
        exp_out   = def;
      end else begin
        exp_busy  = 1'b1;
        exp_valid = 1'b0;
        exp_out   = ((k % p) < we) ? ~def : def;
      end
      check($sformatf("train n%0d w%0d u%0d k%0d .out", n, w, u, k), io_pulseOut, exp_out);
      check($sformatf("train n%0d w%0d u%0d k%0d .busy", n, w, u, k), pulse_busy, exp_busy);
      check($sformatf("train n%0d w%0d u%0d k%0d .valid", n, w, u, k), pulse_valid, exp_valid);
    end
  endtask

  initial begin
    int unsigned rn, rw, ru;
    logic        rdef;

    io_rst           = 1'b1;
    io_en            = 1'b0;
    io_defaultLevel  = 1'b0;
    io_pulseWidth    = '0;
    io_unaccessWidth = '0;
    io_pusle_times   = '0;
    tick();
    check_idle("reset", 1'b0);
    io_rst = 1'b0;
    tick();
    check_idle("post_reset", 1'b0);

    // 10 x (25 high, 15 low); en held high afterwards must not restart
    run_train(10, 25, 15, 1'b0, 400 + 5);
    io_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_idle("gap_after_t2", 1'b0);
    end

    run_train(5, 25, 25, 1'b0, 250 + 3);
    io_en = 1'b0;
    tick();
    check_idle("after_t3", 1'b0);

    // Continuous mode, then abort
    run_train(0, 3, 2, 1'b0, 1005);
    io_en = 1'b0;
    tick();
    check_idle("abort_cont", 1'b0);
    tick();
    check_idle("abort_cont2", 1'b0);

    // Inverted default level; idle output follows it one cycle later
    io_defaultLevel = 1'b1;
    tick();
    check_idle("def1_idle", 1'b1);
    run_train(2, 4, 4, 1'b1, 16 + 4);
    io_en = 1'b0;
    tick();
    check_idle("def1_after", 1'b1);

    // Reset mid-train dominates even with en still high
    io_defaultLevel = 1'b0;
    tick();
    run_train(3, 6, 6, 1'b0, 10);
    io_rst = 1'b1;
    tick();
    check_idle("rst_mid", 1'b0);
    io_en = 1'b0;
    tick();
    check_idle("rst_hold", 1'b0);
    io_rst = 1'b0;
    tick();
    check_idle("rst_release", 1'b0);

    // Abort during the gap phase
    run_train(4, 3, 5, 1'b0, 5);
    io_en = 1'b0;
    tick();
    check_idle("abort_gap", 1'b0);

    for (int t = 0; t < 8; t++) begin
      rn   = $urandom_range(1, 4);
      rw   = $urandom_range(0, 5);
      ru   = $urandom_range(0, 5);
      rdef = 1'($urandom_range(0, 1));
      io_defaultLevel = rdef;
      tick();
      check_idle("rand_pre", rdef);
      run_train(rn, rw, ru, rdef,
                rn * (((rw == 0) ? 1 : rw) + ((ru == 0) ? 1 : ru)) + 3);
      io_en = 1'b0;
      tick();
      check_idle("rand_post", rdef);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
